// File: rtl/urv_defs.sv
// Shared definitions for the uRV load/store path: access-size codes and
// the LSU state encoding.
package urv_defs;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_LOAD  = 2'd1,
    WAIT_STORE = 2'd2,
    DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/urv_lsu_align.sv
// Combinational lane steering: byte enables, store-data replication and
// misalignment detection for one access.
module urv_lsu_align
  import urv_defs::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  select,
  output logic [31:0] store_lanes,
  output logic        misaligned
);

  // Unknown size codes fall through to full-word handling.
  always_comb begin
    select      = 4'b1111;
    store_lanes = store_data;
    misaligned  = 1'b0;
    case (fun)
      LDST_B, LDST_BU: begin
        select      = 4'b0001 << addr_lo;
        store_lanes = {4{store_data[7:0]}};
      end
      LDST_H, LDST_HU: begin
        select      = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
        misaligned  = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/urv_lsu.sv
// uRV load/store unit: accepts one access from execute, drives a single
// strobed bus cycle with timeout, and holds the result for writeback.
module urv_lsu
  import urv_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] x_store_data_i,
  input  logic        w_stall_i,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_load_o,
  output logic        dm_store_o,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_ready_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        misaligned_o,
  output logic        bus_error_o
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  lsu_state_t  state;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_next;
  logic [3:0]  align_select;
  logic [31:0] align_data;
  logic        align_misaligned;
  logic        accept;

  urv_lsu_align u_align (
    .fun         (x_fun_i),
    .addr_lo     (x_dm_addr_i[1:0]),
    .store_data  (x_store_data_i),
    .select      (align_select),
    .store_lanes (align_data),
    .misaligned  (align_misaligned)
  );

  assign accept        = x_valid_i && (x_load_i || x_store_i);
  assign wait_cnt_next = wait_cnt + 16'd1;

  // Load wins when both load and store are flagged.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      dm_addr_o        <= '0;
      dm_data_s_o      <= '0;
      dm_data_select_o <= '0;
      dm_load_o        <= 1'b0;
      dm_store_o       <= 1'b0;
      dm_data_l_o      <= '0;
      dm_load_done_o   <= 1'b0;
      dm_store_done_o  <= 1'b0;
      misaligned_o     <= 1'b0;
      bus_error_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wait_cnt <= '0;
            if (align_misaligned) begin
              state           <= DONE;
              misaligned_o    <= 1'b1;
              dm_load_done_o  <= x_load_i;
              dm_store_done_o <= !x_load_i;
            end else begin
              dm_addr_o        <= {x_dm_addr_i[31:2], 2'b00};
              dm_data_s_o      <= align_data;
              dm_data_select_o <= align_select;
              if (x_load_i) begin
                dm_load_o <= 1'b1;
                state     <= WAIT_LOAD;
              end else begin
                dm_store_o <= 1'b1;
                state      <= WAIT_STORE;
              end
            end
          end
        end

        WAIT_LOAD, WAIT_STORE: begin
          if (dm_ready_i) begin
            dm_load_o  <= 1'b0;
            dm_store_o <= 1'b0;
            state      <= DONE;
            if (state == WAIT_LOAD) begin
              dm_data_l_o    <= dm_data_l_i;
              dm_load_done_o <= 1'b1;
            end else begin
              dm_store_done_o <= 1'b1;
            end
          end else if (wait_cnt_next >= TIMEOUT_LIMIT) begin
            wait_cnt        <= wait_cnt_next;
            dm_load_o       <= 1'b0;
            dm_store_o      <= 1'b0;
            dm_data_l_o     <= '0;
            bus_error_o     <= 1'b1;
            dm_load_done_o  <= (state == WAIT_LOAD);
            dm_store_done_o <= (state == WAIT_STORE);
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt_next;
          end
        end

        DONE: begin
          if (!w_stall_i) begin
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            misaligned_o    <= 1'b0;
            bus_error_o     <= 1'b0;
            state           <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_lsu.sv
// Directed scoreboard bench for urv_lsu, run with a short bus timeout.
module tb_urv_lsu;
  import urv_defs::*;

  logic        clk;
  logic        rst_n;
  logic        x_valid;
  logic        x_load;
  logic        x_store;
  logic [2:0]  x_fun;
  logic [31:0] x_addr;
  logic [31:0] x_sdata;
  logic        w_stall;
  logic [31:0] dm_addr;
  logic [31:0] dm_data_s;
  logic [3:0]  dm_sel;
  logic        dm_load;
  logic        dm_store;
  logic [31:0] dm_data_l_in;
  logic        dm_ready;
  logic [31:0] dm_data_l;
  logic        load_done;
  logic        store_done;
  logic        misaligned;
  logic        bus_error;

  typedef struct packed {
    logic        load_done;
    logic        store_done;
    logic        misaligned;
    logic        bus_error;
    logic        strobe;
    logic [31:0] data_l;
  } res_t;

  res_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] model_data_l = '0;

  urv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .x_valid_i        (x_valid),
    .x_load_i         (x_load),
    .x_store_i        (x_store),
    .x_fun_i          (x_fun),
    .x_dm_addr_i      (x_addr),
    .x_store_data_i   (x_sdata),
    .w_stall_i        (w_stall),
    .dm_addr_o        (dm_addr),
    .dm_data_s_o      (dm_data_s),
    .dm_data_select_o (dm_sel),
    .dm_load_o        (dm_load),
    .dm_store_o       (dm_store),
    .dm_data_l_i      (dm_data_l_in),
    .dm_ready_i       (dm_ready),
    .dm_data_l_o      (dm_data_l),
    .dm_load_done_o   (load_done),
    .dm_store_done_o  (store_done),
    .misaligned_o     (misaligned),
    .bus_error_o      (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access from a negedge with the FSM idle, answers the strobe
  // after ready_after wait cycles (negative: never), stalls writeback for
  // stall_cycles, and reports what the bus and writeback sides showed.
  task automatic run_access(
    input  logic        ld,
    input  logic        st,
    input  logic [2:0]  fun,
    input  logic [31:0] addr,
    input  logic [31:0] sdata,
    input  logic [31:0] ldata,
    input  int          ready_after,
    input  int          stall_cycles,
    output int          strobe_cycles,
    output logic [31:0] s_addr,
    output logic [31:0] s_data,
    output logic [3:0]  s_sel,
    output logic        stable,
    output logic        got_done,
    output res_t        res,
    output int          done_cycles
  );
    x_valid      = 1'b1;
    x_load       = ld;
    x_store      = st;
    x_fun        = fun;
    x_addr       = addr;
    x_sdata      = sdata;
    dm_data_l_in = ldata;
    w_stall      = 1'b0;
    @(negedge clk);
    x_valid       = 1'b0;
    x_load        = 1'b0;
    x_store       = 1'b0;
    strobe_cycles = 0;
    stable        = 1'b1;
    got_done      = 1'b0;
    s_addr        = '0;
    s_data        = '0;
    s_sel         = '0;
    res           = '0;
    for (int i = 0; i < 300; i++) begin
      if (load_done || store_done) begin
        got_done = 1'b1;
        res = '{load_done, store_done, misaligned, bus_error,
                dm_load | dm_store, dm_data_l};
        break;
      end
      if (dm_load || dm_store) begin
        if (strobe_cycles == 0) begin
          s_addr = dm_addr;
          s_data = dm_data_s;
          s_sel  = dm_sel;
        end else if (s_addr != dm_addr || s_data != dm_data_s || s_sel != dm_sel) begin
          stable = 1'b0;
        end
        dm_ready = (ready_after >= 0) && (strobe_cycles == ready_after);
        strobe_cycles++;
      end else begin
        dm_ready = 1'b0;
      end
      @(negedge clk);
    end
    dm_ready    = 1'b0;
    done_cycles = 0;
    while ((load_done || store_done) && done_cycles < 50) begin
      w_stall = (done_cycles < stall_cycles);
      done_cycles++;
      @(negedge clk);
    end
    w_stall = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    x_valid      = 1'b0;
    x_load       = 1'b0;
    x_store      = 1'b0;
    x_fun        = LDST_L;
    x_addr       = '0;
    x_sdata      = '0;
    w_stall      = 1'b0;
    dm_data_l_in = '0;
    dm_ready     = 1'b0;
    #3;
    checks++;
    if ({dm_addr, dm_data_s, dm_sel, dm_load, dm_store, dm_data_l,
         load_done, store_done, misaligned, bus_error} !== '0)
      $display("[TB] FAIL reset_async: outputs=%h required 0",
               {dm_addr, dm_data_s, dm_sel, dm_load, dm_store, dm_data_l});
    else passed++;
    @(negedge clk);
    x_valid = 1'b1;
    x_load  = 1'b1;
    dm_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({dm_load, dm_store, load_done, store_done, misaligned, bus_error} !== 6'b0)
      $display("[TB] FAIL reset_held: flags=%b required 000000",
               {dm_load, dm_store, load_done, store_done, misaligned, bus_error});
    else passed++;
    x_valid  = 1'b0;
    x_load   = 1'b0;
    dm_ready = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    int sc, dc;
    logic [31:0] a, d;
    logic [3:0] s;
    logic stb, gd;
    res_t r, e;
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_data_l});
    run_access(1'b0, 1'b1, LDST_L, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
               sc, a, d, s, stb, gd, r, dc);
    e = exp_q.pop_front();
    checks++;
    if (sc !== 1) $display("[TB] FAIL sw_strobe_len: got %0d required 1", sc); else passed++;
    checks++;
    if (a !== 32'h100) $display("[TB] FAIL sw_addr: got %h required 00000100", a); else passed++;
    checks++;
    if (s !== 4'b1111) $display("[TB] FAIL sw_select: got %b required 1111", s); else passed++;
    checks++;
    if (d !== 32'hDEADBEEF) $display("[TB] FAIL sw_data: got %h required deadbeef", d); else passed++;
    checks++;
    if (!gd || r !== e) $display("[TB] FAIL sw_result: got %h required %h", r, e); else passed++;
    checks++;
    if (dc !== 1) $display("[TB] FAIL sw_done_len: got %0d required 1", dc); else passed++;
  endtask

  task automatic test_store_byte_wait();
    int sc, dc;
    logic [31:0] a, d;
    logic [3:0] s;
    logic stb, gd;
    res_t r, e;
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, model_data_l});
    run_access(1'b0, 1'b1, LDST_B, 32'h203, 32'h000000A5, 32'h0, 3, 0,
               sc, a, d, s, stb, gd, r, dc);
    e = exp_q.pop_front();
    checks++;
    if (sc !== 4) $display("[TB] FAIL sb_strobe_len: got %0d required 4", sc); else passed++;
    checks++;
    if (a !== 32'h200) $display("[TB] FAIL sb_addr: got %h required 00000200", a); else passed++;
    checks++;
    if (s !== 4'b1000) $display("[TB] FAIL sb_select: got %b required 1000", s); else passed++;
    checks++;
    if (d !== 32'hA5A5A5A5) $display("[TB] FAIL sb_data: got %h required a5a5a5a5", d); else passed++;
    checks++;
    if (stb !== 1'b1) $display("[TB] FAIL sb_stable: got %b required 1", stb); else passed++;
    checks++;
    if (!gd || r !== e) $display("[TB] FAIL sb_result: got %h required %h", r, e); else passed++;
  endtask

  task automatic test_load_half_stall();
    int sc, dc;
    logic [31:0] a, d;
    logic [3:0] s;
    logic stb, gd;
    res_t r, e;
    model_data_l = 32'h12345678;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, model_data_l});
    run_access(1'b1, 1'b0, LDST_H, 32'h42, 32'h0, 32'h12345678, 0, 2,
               sc, a, d, s, stb, gd, r, dc);
    e = exp_q.pop_front();
    checks++;
    if (s !== 4'b1100) $display("[TB] FAIL lh_select: got %b required 1100", s); else passed++;
    checks++;
    if (a !== 32'h40) $display("[TB] FAIL lh_addr: got %h required 00000040", a); else passed++;
    checks++;
    if (!gd || r !== e) $display("[TB] FAIL lh_result: got %h required %h", r, e); else passed++;
    checks++;
    if (dc !== 3) $display("[TB] FAIL lh_done_len: got %0d required 3", dc); else passed++;
    checks++;
    if (load_done !== 1'b0 || dm_data_l !== 32'h12345678)
      $display("[TB] FAIL lh_after_done: done=%b data=%h required 0/12345678", load_done, dm_data_l);
    else passed++;
  endtask

  task automatic test_misaligned();
    int sc, dc;
    logic [31:0] a, d;
    logic [3:0] s;
    logic stb, gd;
    res_t r, e;
    exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, model_data_l});
    run_access(1'b1, 1'b0, LDST_L, 32'h102, 32'h0, 32'hFFFFFFFF, 0, 0,
               sc, a, d, s, stb, gd, r, dc);
    e = exp_q.pop_front();
    checks++;
    if (sc !== 0) $display("[TB] FAIL mis_strobe: got %0d required 0", sc); else passed++;
    checks++;
    if (!gd || r !== e) $display("[TB] FAIL mis_result: got %h required %h", r, e); else passed++;
    checks++;
    if (dc !== 1) $display("[TB] FAIL mis_done_len: got %0d required 1", dc); else passed++;
  endtask

  task automatic test_timeout();
    int sc, dc;
    logic [31:0] a, d;
    logic [3:0] s;
    logic stb, gd;
    res_t r, e;
    model_data_l = '0;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    run_access(1'b1, 1'b0, LDST_L, 32'h300, 32'h0, 32'hCAFEF00D, -1, 0,
               sc, a, d, s, stb, gd, r, dc);
    e = exp_q.pop_front();
    checks++;
    if (sc !== 4) $display("[TB] FAIL to_wait_len: got %0d required 4", sc); else passed++;
    checks++;
    if (!gd || r !== e) $display("[TB] FAIL to_result: got %h required %h", r, e); else passed++;
  endtask

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  fun;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] ldata;
    logic [3:0]  sel;
    logic [31:0] lanes;
    logic        mis;
  } lane_t;

  task automatic test_lanes();
    lane_t tbl [9];
    int sc, dc;
    logic [31:0] a, d;
    logic [3:0] s;
    logic stb, gd;
    res_t r, e;
    tbl = '{
      '{1'b0, 1'b1, LDST_H,  32'h002, 32'h1234BEEF, 32'h0,        4'b1100, 32'hBEEFBEEF, 1'b0},
      '{1'b0, 1'b1, LDST_H,  32'h000, 32'hCAFE0011, 32'h0,        4'b0011, 32'h00110011, 1'b0},
      '{1'b1, 1'b0, LDST_BU, 32'h001, 32'h0,        32'hA1B2C3D4, 4'b0010, 32'h0,        1'b0},
      '{1'b1, 1'b0, LDST_B,  32'h003, 32'h0,        32'h0F0F0F0F, 4'b1000, 32'h0,        1'b0},
      '{1'b1, 1'b0, LDST_HU, 32'h002, 32'h0,        32'h13572468, 4'b1100, 32'h0,        1'b0},
      '{1'b1, 1'b1, LDST_L,  32'h010, 32'h99999999, 32'h55AA55AA, 4'b1111, 32'h0,        1'b0},
      '{1'b0, 1'b1, LDST_B,  32'h002, 32'h00000077, 32'h0,        4'b0100, 32'h77777777, 1'b0},
      '{1'b0, 1'b1, LDST_H,  32'h003, 32'h00001111, 32'h0,        4'b0000, 32'h0,        1'b1},
      '{1'b1, 1'b0, LDST_HU, 32'h001, 32'h0,        32'hEEEEEEEE, 4'b0000, 32'h0,        1'b1}
    };
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].ld && !tbl[i].mis) model_data_l = tbl[i].ldata;
      exp_q.push_back('{tbl[i].ld, !tbl[i].ld, tbl[i].mis, 1'b0, 1'b0, model_data_l});
      run_access(tbl[i].ld, tbl[i].st, tbl[i].fun, tbl[i].addr, tbl[i].sdata,
                 tbl[i].ldata, i % 3, 0, sc, a, d, s, stb, gd, r, dc);
      e = exp_q.pop_front();
      checks++;
      if (!gd || r !== e) $display("[TB] FAIL lane%0d_result: got %h required %h", i, r, e);
      else passed++;
      checks++;
      if (sc !== (tbl[i].mis ? 0 : (i % 3) + 1))
        $display("[TB] FAIL lane%0d_strobe_len: got %0d required %0d", i, sc,
                 tbl[i].mis ? 0 : (i % 3) + 1);
      else passed++;
      if (!tbl[i].mis) begin
        checks++;
        if (s !== tbl[i].sel || a !== {tbl[i].addr[31:2], 2'b00})
          $display("[TB] FAIL lane%0d_select: got %b/%h required %b/%h", i, s, a,
                   tbl[i].sel, {tbl[i].addr[31:2], 2'b00});
        else passed++;
        if (!tbl[i].ld) begin
          checks++;
          if (d !== tbl[i].lanes)
            $display("[TB] FAIL lane%0d_data: got %h required %h", i, d, tbl[i].lanes);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    x_valid = 1'b1;
    x_store = 1'b1;
    x_fun   = LDST_L;
    x_addr  = 32'h400;
    x_sdata = 32'h0BADF00D;
    @(negedge clk);
    x_valid = 1'b0;
    x_store = 1'b0;
    checks++;
    if (dm_store !== 1'b1) $display("[TB] FAIL rst_mid_strobe: got %b required 1", dm_store);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dm_addr, dm_data_s, dm_sel, dm_load, dm_store, dm_data_l,
         load_done, store_done, misaligned, bus_error} !== '0)
      $display("[TB] FAIL rst_mid_async: addr=%h store=%b required 0/0", dm_addr, dm_store);
    else passed++;
    @(negedge clk);
    rst_n    = 1'b1;
    dm_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({dm_load, dm_store, load_done, store_done, bus_error} !== 5'b0)
        $display("[TB] FAIL rst_mid_late_ready%0d: flags=%b required 00000", i,
                 {dm_load, dm_store, load_done, store_done, bus_error});
      else passed++;
    end
    dm_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte_wait();
    test_load_half_stall();
    test_misaligned();
    test_timeout();
    test_lanes();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/urv_lsu.md
URV_LSU -- requirements
Module: urv_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of wait cycles without dm_ready_i before the bus access is abandoned.
REQ-002 SHALL have ports:
- clk_i  in  1  sole clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- x_valid_i  in  1  execute-stage instruction valid.
- x_load_i  in  1  instruction is a load.
- x_store_i  in  1  instruction is a store.
- x_fun_i  in  3  LDST_B/BU/H/HU/L access code.
- x_dm_addr_i  in  32  byte address.
- x_store_data_i  in  32  unaligned rs2 store value.
- w_stall_i  in  1  writeback not accepting this cycle.
- dm_addr_o  out  32  word address, bits [1:0] always 0.
- dm_data_s_o  out  32  lane-replicated store data.
- dm_data_select_o  out  4  byte enables.
- dm_load_o  out  1  load strobe.
- dm_store_o  out  1  store strobe.
- dm_data_l_i  in  32  raw load word.
- dm_ready_i  in  1  bus completion, one cycle.
- dm_data_l_o  out  32  registered load word to writeback.
- dm_load_done_o  out  1  load complete.
- dm_store_done_o  out  1  store complete.
- misaligned_o  out  1  access is misaligned; no bus cycle issued.
- bus_error_o  out  1  access timed out.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_LOAD, WAIT_STORE, DONE.
REQ-004 In IDLE, a cycle with x_valid_i and (x_load_i or x_store_i) SHALL be accepted; dm_load_o or dm_store_o SHALL go high the next cycle and the FSM SHALL enter WAIT_LOAD or WAIT_STORE.
REQ-005 Strobe and address/data/select outputs SHALL be held stable until dm_ready_i is sampled high; the strobe SHALL drop the cycle after dm_ready_i.
REQ-006 dm_ready_i SHALL be honoured from the first strobe cycle onward; minimum latency is request at N, strobe at N+1, ready at N+1, done at N+2.
REQ-007 On dm_ready_i in WAIT_LOAD, dm_data_l_i SHALL be captured into dm_data_l_o, and the FSM SHALL enter DONE with dm_load_done_o=1; WAIT_STORE behaves the same with dm_store_done_o=1.
REQ-008 Byte enables: B/BU SHALL give 1<<addr[1:0]; H/HU SHALL give 0011 (addr[1]=0) or 1100; L SHALL give 1111. This applies to loads and stores.
REQ-009 Store data SHALL replicate the low byte ×4 for B, the low halfword ×2 for H, and pass through unchanged for L.
REQ-010 Misaligned accesses are H/HU with addr[0]=1 and L with addr[1:0]≠0. These SHALL issue no strobe, SHALL go IDLE→DONE with the matching done flag and misaligned_o=1, and dm_data_l_o SHALL be unchanged.
REQ-011 A 16-bit wait counter SHALL clear on accept and increment each WAIT cycle without dm_ready_i. On reaching TIMEOUT_CYCLES, the strobe SHALL drop, the FSM SHALL enter DONE with the done flag and bus_error_o=1, and dm_data_l_o SHALL be 0.
REQ-012 DONE SHALL hold the done, misaligned and bus_error outputs while w_stall_i=1. On the first cycle with w_stall_i=0 the FSM SHALL return to IDLE, and these outputs SHALL be 0 the following cycle.
REQ-013 Requests arriving outside IDLE SHALL be ignored (upstream is held by the writeback stall request); dm_ready_i in IDLE or DONE SHALL be ignored.
REQ-014 If x_load_i and x_store_i are both set, the access SHALL be treated as a load.

Reset
REQ-015 While rst_n_i=0, all outputs SHALL be 0, the FSM SHALL be in IDLE and the counter SHALL be 0, independent of clk_i. This includes reset mid-access: the strobe drops immediately and a late dm_ready_i is ignored.

Structure
REQ-016 LDST_* codes and FSM state encodings SHALL live in the shared urv_defs package.
REQ-017 Lane steering (REQ-008/009/010) SHALL be a combinational sub-module urv_lsu_align; the FSM and counter SHALL stay in urv_lsu.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- SW 0xDEADBEEF to 0x100, dm_ready_i on the strobe cycle → addr 0x100, select 1111, data 0xDEADBEEF, store_done at N+2 for 1 cycle.
- SB 0x000000A5 to 0x203, ready after 3 wait cycles → addr 0x200, select 1000, data 0xA5A5A5A5, strobe held 4 cycles.
- LH 0x42 with dm_data_l_i=0x12345678, w_stall_i=1 for 2 cycles in DONE → select 1100, dm_data_l_o=0x12345678, load_done high 3 cycles.
- LW at 0x102 → no strobe, load_done and misaligned_o for 1 cycle.
- TIMEOUT_CYCLES=4, dm_ready_i never asserted → bus_error_o with load_done after 4 wait cycles, strobe low, dm_data_l_o=0.
- rst_n_i pulsed low mid-WAIT_STORE, then dm_ready_i → outputs 0 asynchronously, no done afterwards.
